ipr2_motion_trigger: RTL and testbench

Parametrised block-average motion trigger for the image-processing accelerator. It consumes a raster pixel stream, reduces each frame to a grid of BxB block means, compares every block mean with the same block of the previous frame, and counts blocks whose absolute difference exceeds a sensitivity. It raises a held trigger when the per-frame count exceeds a threshold. It sits after the sensor/capture front end and drives the event/recording controller.

---
 rtl/ipr_pkg.sv | 29 ++
 rtl/ipr_dp_ram.sv | 28 ++
 rtl/ipr2_motion_trigger.sv | 207 ++++++++++++++++++++
 tb/tb_ipr2_motion_trigger.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipr_pkg.sv
// Shared constants and helpers for the block-average motion trigger.
package ipr_pkg;

  // Derived sizes at the default geometry (512x512 frame, 8-bit pixels, 8x8 blocks).
  localparam int BLK_COLS  = 512 >> 3;
  localparam int BLK_ROWS  = 512 >> 3;
  localparam int ACC_W     = 8 + 2 * 3;
  localparam int REF_DEPTH = (512 * 512) >> (2 * 3);

  // Width of the absolute-difference datapath; pixels up to 16 bits are supported.
  localparam int ABS_W = 16;

  // Blocks per line for a given geometry.
  function automatic int blk_cols(input int img_w, input int blk_log2);
    return img_w >> blk_log2;
  endfunction

  // Blocks per frame for a given geometry.
  function automatic int ref_depth(input int img_w, input int img_h, input int blk_log2);
    return (img_w * img_h) >> (2 * blk_log2);
  endfunction

  // Unsigned absolute difference.
  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ipr_dp_ram.sv
// Synchronous simple dual-port RAM, 1-cycle registered read, read-before-write.
module ipr_dp_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; holds its data until the next read, returns old data on collision.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ipr2_motion_trigger.sv
// Block-average motion trigger: per-frame block means compared with the previous frame.
//
// Stream semantics: there is no back-pressure. A pixel is taken on every clock edge
// where frame_valid & data_valid are both high; data_valid may gap freely inside a frame.
module ipr2_motion_trigger
  import ipr_pkg::*;
#(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 512,
  parameter int PIX_W       = 8,
  parameter int BLK_LOG2    = 3,
  parameter int CNT_W       = 16,
  parameter int HOLD_FRAMES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             frame_valid,
  input  logic             data_valid,
  input  logic             enable,
  input  logic [PIX_W-1:0] sensitivity,
  input  logic [CNT_W-1:0] threshold,
  output logic             trigger_out,
  output logic [CNT_W-1:0] change_count,
  output logic             count_valid,
  output logic             frame_error,
  output logic             o_frame_valid,
  output logic             o_data_valid
);

  localparam int NCOL  = blk_cols(IMG_W, BLK_LOG2);
  localparam int NBLK  = ref_depth(IMG_W, IMG_H, BLK_LOG2);
  localparam int HW    = PIX_W + BLK_LOG2;
  localparam int AW    = PIX_W + 2 * BLK_LOG2;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int CAW   = $clog2(NCOL);
  localparam int RAW   = $clog2(NBLK);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int PCW   = $clog2(TOTAL) + 1;  // headroom so oversized frames stay distinguishable

  logic [XW-1:0]    x_q, x_cur;
  logic [YW-1:0]    y_q, y_cur;
  logic [PCW-1:0]   pix_cnt, pix_cur;
  logic [HW-1:0]    hsum_q, hsum_tot;
  logic [AW-1:0]    col_rd, col_sum;
  logic [CAW-1:0]   col_cur;
  logic [RAW-1:0]   ref_addr, s1_addr;
  logic [PIX_W-1:0] blk_mean, s1_mean, s2_mean, ref_old, sens_q;
  logic [CNT_W-1:0] thr_q, cnt_q;
  logic [7:0]       hold_q;
  logic [2:0]       end_sr;
  logic             rise, fall, take, accept, pre_end, row_end, blk_end;
  logic             s1_vld, s2_vld, chg_q, ref_valid, cmp_en;

  assign rise    = frame_valid & ~o_frame_valid;
  assign fall    = ~frame_valid & o_frame_valid;
  assign take    = frame_valid & data_valid;
  assign x_cur   = rise ? '0 : x_q;
  assign y_cur   = rise ? '0 : y_q;
  assign pix_cur = rise ? '0 : pix_cnt;
  assign accept  = take & (pix_cur < PCW'(TOTAL));
  assign pre_end = accept & (x_cur[BLK_LOG2-1:0] == BLK_LOG2'((1 << BLK_LOG2) - 2));
  assign row_end = accept & (&x_cur[BLK_LOG2-1:0]);
  assign blk_end = row_end & (&y_cur[BLK_LOG2-1:0]);
  assign col_cur = CAW'(x_cur >> BLK_LOG2);
  assign ref_addr = RAW'(RAW'(y_cur >> BLK_LOG2) * RAW'(NCOL)) + RAW'(col_cur);

  // Horizontal sum restarts at the first pixel of each block row.
  assign hsum_tot = ((x_cur[BLK_LOG2-1:0] == '0) ? '0 : hsum_q) + HW'(pixel_in);
  // The first row of a block band overwrites the column accumulator.
  assign col_sum  = ((y_cur[BLK_LOG2-1:0] == '0) ? '0 : col_rd) + AW'(hsum_tot);
  assign blk_mean = PIX_W'(col_sum >> (2 * BLK_LOG2));
  assign cmp_en   = ref_valid & enable;

  // Output copies of the stream strobes; o_frame_valid doubles as the edge detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_frame_valid <= 1'b0;
      o_data_valid  <= 1'b0;
    end else begin
      o_frame_valid <= frame_valid;
      o_data_valid  <= data_valid;
    end
  end

  // Coordinate counters, pixel count and horizontal sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      pix_cnt <= '0;
      hsum_q  <= '0;
    end else begin
      if (accept) begin
        hsum_q <= hsum_tot;
        if (x_cur == XW'(IMG_W - 1)) begin
          x_q <= '0;
          y_q <= (y_cur == YW'(IMG_H - 1)) ? '0 : y_cur + 1'b1;
        end else begin
          x_q <= x_cur + 1'b1;
          y_q <= y_cur;
        end
      end else if (rise) begin
        x_q <= '0;
        y_q <= '0;
      end
      if (take) pix_cnt <= (&pix_cur) ? pix_cur : pix_cur + 1'b1;
      else if (rise) pix_cnt <= '0;
    end
  end

  ipr_dp_ram #(.DEPTH(NCOL), .WIDTH(AW), .ADDR_W(CAW)) u_col_ram (
    .clk   (clk),
    .we    (row_end),
    .waddr (col_cur),
    .wdata (col_sum),
    .re    (pre_end),
    .raddr (col_cur),
    .rdata (col_rd)
  );

  ipr_dp_ram #(.DEPTH(NBLK), .WIDTH(PIX_W), .ADDR_W(RAW)) u_ref_ram (
    .clk   (clk),
    .we    (s1_vld),
    .waddr (s1_addr),
    .wdata (s1_mean),
    .re    (s1_vld),
    .raddr (s1_addr),
    .rdata (ref_old)
  );

  // Compare pipeline: mean -> reference swap -> registered change flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_mean <= '0;
      s1_addr <= '0;
      s2_vld  <= 1'b0;
      s2_mean <= '0;
      chg_q   <= 1'b0;
    end else begin
      s1_vld  <= blk_end;
      s1_mean <= blk_mean;
      s1_addr <= ref_addr;
      s2_vld  <= s1_vld;
      s2_mean <= s1_mean;
      chg_q   <= s2_vld & cmp_en &
                 (abs_diff(ABS_W'(s2_mean), ABS_W'(ref_old)) > ABS_W'(sens_q));
    end
  end

  // Per-frame settings and the saturating running change counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sens_q <= '0;
      thr_q  <= '0;
      cnt_q  <= '0;
    end else if (rise) begin
      sens_q <= sensitivity;
      thr_q  <= threshold;
      cnt_q  <= '0;
    end else if (chg_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Frame-end evaluation, delayed until the last compare has reached the counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      end_sr       <= '0;
      change_count <= '0;
      count_valid  <= 1'b0;
      frame_error  <= 1'b0;
      trigger_out  <= 1'b0;
      hold_q       <= '0;
      ref_valid    <= 1'b0;
    end else begin
      end_sr      <= {end_sr[1:0], fall};
      count_valid <= 1'b0;
      if (end_sr[2]) begin
        count_valid <= 1'b1;
        if (pix_cnt == PCW'(TOTAL)) begin
          change_count <= cnt_q;
          frame_error  <= 1'b0;
          ref_valid    <= 1'b1;
          if (ref_valid && (cnt_q > thr_q)) begin
            hold_q      <= 8'(HOLD_FRAMES);
            trigger_out <= 1'b1;
          end else if (hold_q != '0) begin
            hold_q      <= hold_q - 1'b1;
            trigger_out <= (hold_q != 8'd1);
          end
        end else begin
          frame_error <= 1'b1;
          ref_valid   <= 1'b0;
        end
      end
      if (!enable) begin
        ref_valid   <= 1'b0;
        trigger_out <= 1'b0;
        hold_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ipr2_motion_trigger.sv
// Directed bench for ipr2_motion_trigger on a 64x32 frame with 4x4 blocks.
module tb_ipr2_motion_trigger;

  localparam int IMG_W = 64;
  localparam int IMG_H = 32;
  localparam int PIX_W = 8;
  localparam int BLK_LOG2 = 2;
  localparam int CNT_W = 16;
  localparam int HOLD_FRAMES = 4;
  localparam int BLK = 1 << BLK_LOG2;
  localparam int NCOL = IMG_W / BLK;
  localparam int NBLK = (IMG_W / BLK) * (IMG_H / BLK);
  localparam int TOTAL = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [PIX_W-1:0] pixel_in = '0;
  logic             frame_valid = 1'b0;
  logic             data_valid = 1'b0;
  logic             enable = 1'b0;
  logic [PIX_W-1:0] sensitivity = '0;
  logic [CNT_W-1:0] threshold = '0;
  logic             trigger_out;
  logic [CNT_W-1:0] change_count;
  logic             count_valid;
  logic             frame_error;
  logic             o_frame_valid;
  logic             o_data_valid;

  ipr2_motion_trigger #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .BLK_LOG2(BLK_LOG2),
    .CNT_W(CNT_W), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in), .frame_valid(frame_valid),
    .data_valid(data_valid), .enable(enable), .sensitivity(sensitivity),
    .threshold(threshold), .trigger_out(trigger_out), .change_count(change_count),
    .count_valid(count_valid), .frame_error(frame_error),
    .o_frame_valid(o_frame_valid), .o_data_valid(o_data_valid)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entry: {trigger_out, frame_error, change_count}.
  logic [CNT_W+1:0] exp_q[$];

  // Reference model state.
  int img [TOTAL];
  int ref_m [NBLK];
  bit m_rv = 0;
  bit m_trig = 0;
  bit m_fe = 0;
  int m_hold = 0;
  int m_cc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pix_idx(input int b, input int dy, input int dx);
    return ((b / NCOL) * BLK + dy) * IMG_W + (b % NCOL) * BLK + dx;
  endfunction

  function automatic int blk_mean(input int b);
    int s = 0;
    for (int dy = 0; dy < BLK; dy++)
      for (int dx = 0; dx < BLK; dx++) s += img[pix_idx(b, dy, dx)];
    return s >> (2 * BLK_LOG2);
  endfunction

  task automatic fill_flat(input int v);
    for (int i = 0; i < TOTAL; i++) img[i] = v;
  endtask

  task automatic set_block(input int b, input int v);
    for (int dy = 0; dy < BLK; dy++)
      for (int dx = 0; dx < BLK; dx++) img[pix_idx(b, dy, dx)] = v;
  endtask

  // Flat 100 background with 20 blocks spread over the frame at value v.
  task automatic fill_twenty(input int v);
    fill_flat(100);
    for (int i = 0; i < 20; i++) set_block(i * 6, v);
  endtask

  // Per-block base level plus pixel noise, so means carry truncated fractions.
  task automatic fill_random();
    for (int b = 0; b < NBLK; b++) begin
      int base = $urandom_range(0, 230);
      for (int dy = 0; dy < BLK; dy++)
        for (int dx = 0; dx < BLK; dx++) img[pix_idx(b, dy, dx)] = base + $urandom_range(0, 25);
    end
  endtask

  // Model a frame of npix pixels and push the expected frame-end result.
  task automatic model_frame(input int npix, input bit en);
    int cnt = 0;
    if (npix == TOTAL) begin
      for (int b = 0; b < NBLK; b++) begin
        int m = blk_mean(b);
        int d = (m > ref_m[b]) ? m - ref_m[b] : ref_m[b] - m;
        if (en && m_rv && d > int'(sensitivity)) cnt++;
        ref_m[b] = m;
      end
      m_cc = cnt;
      m_fe = 0;
      if (m_rv && cnt > int'(threshold)) begin
        m_hold = HOLD_FRAMES;
        m_trig = 1;
      end else if (m_hold != 0) begin
        m_hold--;
        m_trig = (m_hold != 0);
      end
      m_rv = 1;
    end else begin
      m_fe = 1;
      m_rv = 0;
    end
    if (!en) begin
      m_rv = 0;
      m_trig = 0;
      m_hold = 0;
    end
    exp_q.push_back({m_trig, m_fe, CNT_W'(m_cc)});
  endtask

  // Drive one frame; the first pixel arrives together with the frame_valid rise.
  task automatic drive_frame(input string tag, input int npix, input bit gaps);
    frame_valid = 1'b1;
    for (int i = 0; i < npix; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        data_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      data_valid = 1'b1;
      pixel_in = PIX_W'(img[i % TOTAL]);
      @(negedge clk);
      if (i == 0) begin
        check({tag, "_o_fv"}, 32'(o_frame_valid), 32'd1);
        check({tag, "_o_dv"}, 32'(o_data_valid), 32'd1);
      end
    end
    data_valid = 1'b0;
    frame_valid = 1'b0;
  endtask

  // Wait (bounded) for the frame-end pulse and compare against the scoreboard.
  task automatic wait_result(input string tag);
    bit seen = 0;
    logic [CNT_W+1:0] e;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (count_valid) seen = 1;
    end
    if (!seen || exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_result: observed pulse=%0d queued=%0d expected pulse=1 queued>0",
               tag, seen, exp_q.size());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check({tag, "_count"}, 32'(change_count), 32'(e[CNT_W-1:0]));
      check({tag, "_trig"}, 32'(trigger_out), 32'(e[CNT_W+1]));
      check({tag, "_ferr"}, 32'(frame_error), 32'(e[CNT_W]));
      @(negedge clk);
      check({tag, "_pulse"}, 32'(count_valid), 32'd0);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int npix, input bit gaps);
    model_frame(npix, enable);
    drive_frame(tag, npix, gaps);
    wait_result(tag);
  endtask

  initial begin
    // Reset.
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trigger_out), 32'd0);
    check("rst_count", 32'(change_count), 32'd0);
    check("rst_cv", 32'(count_valid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_ofv", 32'(o_frame_valid), 32'd0);
    check("rst_odv", 32'(o_data_valid), 32'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    sensitivity = 8'd30;
    threshold = 16'd10;
    repeat (3) @(negedge clk);

    // Two identical flat frames: first builds the reference, neither triggers.
    fill_flat(100);
    run_frame("flat1", TOTAL, 0);
    run_frame("flat2", TOTAL, 0);

    // Twenty changed blocks over threshold 10, then flat frames run the hold down.
    fill_twenty(140);
    run_frame("motion", TOTAL, 0);
    fill_flat(100);
    for (int f = 0; f < 5; f++) run_frame("hold", TOTAL, 0);

    // Difference exactly at sensitivity is not counted; one above is.
    set_block(0, 130);
    set_block(1, 131);
    run_frame("sens_edge", TOTAL, 0);
    fill_flat(100);
    run_frame("sens_back", TOTAL, 0);

    // Short frame: error, count kept, reference invalidated.
    run_frame("short", 1000, 0);
    fill_twenty(200);
    run_frame("after_short", TOTAL, 0);
    fill_flat(100);
    run_frame("rebuilt", TOTAL, 0);

    // Dropping enable clears the held trigger straight away.
    enable = 1'b0;
    m_trig = 0;
    m_hold = 0;
    m_rv = 0;
    repeat (2) @(negedge clk);
    check("en_drop_trig", 32'(trigger_out), 32'd0);
    fill_random();
    run_frame("en_low", TOTAL, 0);
    enable = 1'b1;
    fill_twenty(200);
    run_frame("reenable1", TOTAL, 0);
    fill_flat(100);
    run_frame("reenable2", TOTAL, 0);

    // Count equal to threshold does not retrigger.
    threshold = 16'd20;
    fill_twenty(200);
    run_frame("thr_equal", TOTAL, 0);

    // Oversized frame: extra pixels ignored but flagged.
    run_frame("oversize", TOTAL + 10, 0);

    // Random content with gaps in data_valid.
    sensitivity = 8'd20;
    threshold = 16'd60;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame("random", TOTAL, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #5000000;
    n_err++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "time limit");
  end

endmodule
